// File: rtl/mod_74x169_n.sv
// mod_74x169_n: parametrised synchronous up/down binary counter built as a
// cascade of WIDTH/4 74x169-style nibble slices with internal carry chaining
// and one active-low ripple-carry output.
//
// WIDTH must be a multiple of 4, minimum 4.
//
// Optional build macro MOD_74X169_N_INV_OUT_EN: when defined, an inverter bank
// drives Q = ~cnt. Loading, counting and RCO_N always work on the true count,
// never on the inverted outputs.
module mod_74x169_n #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD_N,
    input  logic             ENP_N,
    input  logic             ENT_N,
    input  logic             U_D,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO_N
);

    localparam int NSLICE = WIDTH / 4;

    // A nibble is terminal when the next count in the current direction
    // would wrap it: 1111 counting up, 0000 counting down.
    function automatic logic nib_term(input logic [3:0] nib, input logic up);
        logic term_v;
        if (up) begin
            term_v = (nib == 4'hF);
        end else begin
            term_v = (nib == 4'h0);
        end
        return term_v;
    endfunction

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             all_term_s;
    logic             rco_n_s;

    // Slice carry chain: slice k steps only when both enables are active and
    // every lower slice is at its terminal value; also gathers full-width
    // terminal detection for the ripple-carry output.
    always_comb begin
        logic carry_v;
        logic term_v;
        cnt_nxt_s = cnt_r;
        carry_v   = ~ENP_N & ~ENT_N;
        term_v    = 1'b1;
        for (int k = 0; k < NSLICE; k++) begin
            if (carry_v) begin
                if (U_D) begin
                    cnt_nxt_s[4*k +: 4] = cnt_r[4*k +: 4] + 4'd1;
                end else begin
                    cnt_nxt_s[4*k +: 4] = cnt_r[4*k +: 4] - 4'd1;
                end
            end else begin
                cnt_nxt_s[4*k +: 4] = cnt_r[4*k +: 4];
            end
            carry_v = carry_v & nib_term(cnt_r[4*k +: 4], U_D);
            term_v  = term_v & nib_term(cnt_r[4*k +: 4], U_D);
        end
        all_term_s = term_v;
    end

    // Ripple carry is combinational so a downstream stage gated by it sees
    // the carry in the same cycle; it ignores ENP_N, LD_N and RST.
    always_comb begin
        if (!ENT_N && all_term_s) begin
            rco_n_s = 1'b0;
        end else begin
            rco_n_s = 1'b1;
        end
    end

    assign RCO_N = rco_n_s;

    // Count register: reset beats load, load beats counting, otherwise the
    // slice chain decides (holding when the enables are inactive).
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (!LD_N) begin
            cnt_r <= D;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

`ifdef MOD_74X169_N_INV_OUT_EN
    assign Q = ~cnt_r;
`else
    assign Q = cnt_r;
`endif

endmodule

// File: tb/tb_mod_74x169_n.sv
// Self-checking bench for mod_74x169_n (WIDTH=8): directed sequence followed by
// randomized stimulus. A reference model computes each expected output from
// the counter's arithmetic rules; expectations go into a queue, and a monitor
// pops and compares after every rising edge.
module tb_mod_74x169_n;

    localparam int W = 8;
`ifdef MOD_74X169_N_INV_OUT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         ld_n;
    logic         enp_n;
    logic         ent_n;
    logic         u_d;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         rco_n;

    int tests;
    int fails;
    int model_cnt;
    logic [W:0] exp_q[$];

    mod_74x169_n #(.WIDTH(W)) dut (
        .CLK  (clk),
        .RST  (rst),
        .LD_N (ld_n),
        .ENP_N(enp_n),
        .ENT_N(ent_n),
        .U_D  (u_d),
        .D    (d),
        .Q    (q),
        .RCO_N(rco_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_rco(input int c, input logic ent, input logic up);
        logic r;
        r = 1'b1;
        if (!ent && ((up && c == 255) || (!up && c == 0))) r = 1'b0;
        return r;
    endfunction

    function automatic logic [W-1:0] model_q(input int c);
        logic [W-1:0] v;
        v = c[W-1:0];
        if (INV) v = ~v;
        return v;
    endfunction

    // Apply one cycle of inputs at the falling edge, check the same-cycle
    // ripple carry, advance the model and queue the post-edge expectation.
    task automatic step(input logic r, input logic ld, input logic enp,
                        input logic ent, input logic up, input logic [W-1:0] dv);
        logic exp_r;
        @(negedge clk);
        rst = r; ld_n = ld; enp_n = enp; ent_n = ent; u_d = up; d = dv;
        #1;
        if (model_cnt >= 0) begin
            exp_r = model_rco(model_cnt, ent, up);
            tests++;
            if (rco_n !== exp_r) begin
                fails++;
                $display("FAIL rco_same_cycle: got %b expected %b (cnt=%0d ent_n=%b u_d=%b)",
                         rco_n, exp_r, model_cnt, ent, up);
            end
        end
        if (r) model_cnt = 0;
        else if (!ld) model_cnt = int'(dv);
        else if (!enp && !ent && model_cnt >= 0) begin
            if (up) model_cnt = (model_cnt + 1) % 256;
            else    model_cnt = (model_cnt + 255) % 256;
        end
        if (model_cnt >= 0)
            exp_q.push_back({model_rco(model_cnt, ent, up), model_q(model_cnt)});
    endtask

    // Monitor: after each rising edge, compare outputs against the oldest
    // queued expectation.
    initial begin
        logic [W:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (q !== e[W-1:0]) begin
                    fails++;
                    $display("FAIL q: got %h expected %h", q, e[W-1:0]);
                end
                tests++;
                if (rco_n !== e[W]) begin
                    fails++;
                    $display("FAIL rco_n: got %b expected %b (q=%h)", rco_n, e[W], q);
                end
            end
        end
    end

    initial begin
        int r;
        logic [W-1:0] dv;
        int wait_cnt;
        tests = 0; fails = 0; model_cnt = -1;
        rst = 1'b1; ld_n = 1'b1; enp_n = 1'b1; ent_n = 1'b0; u_d = 1'b1; d = 8'h00;

        // Reset, then direction switch while holding.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        // Load FD, count to FF, wrap to 00.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFD);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        // Nibble carry up and borrow down, down-wrap from 00.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0F);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // Hold at FF with ENP_N inactive, then ENT_N inactive.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        // Reset beats load; load beats counting.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        // Randomized phase biased toward terminal values.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 4))
                0: dv = 8'hFF;
                1: dv = 8'h00;
                2: dv = 8'h0F;
                3: dv = 8'hF0;
                default: dv = 8'($urandom);
            endcase
            step((r < 3) ? 1'b1 : 1'b0,
                 (r >= 3 && r < 15) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1,
                 dv);
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
